// File: rtl/packet_reassembly.sv
// Fragment-checking pass-through for an AXI-Stream transfer: counts beats against mss and
// transfer_size, flags short/long fragments, and regenerates tlast on the final beat.
module packet_reassembly #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  trigger,
  input  logic [31:0]           mss,
  input  logic [31:0]           transfer_size,
  output logic                  transfer_init,
  output logic                  transfer_completed,
  output logic [15:0]           fragment_count,
  output logic                  err_short,
  output logic                  err_long
);

  typedef enum logic [1:0] {WAIT_TRIGGER, RECEIVE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_trig_q;
  logic                  r_done;
  logic                  w_done_next;
  logic [31:0]           r_mss;
  logic [31:0]           r_size;
  logic [31:0]           r_total;
  logic [31:0]           r_frag;
  logic [31:0]           r_frag_base;
  logic [15:0]           r_frag_cnt;
  logic                  r_err_short;
  logic                  r_err_long;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_cnt;

  logic                  w_trig_edge;
  logic                  w_push;
  logic                  w_pop;
  logic [31:0]           w_remaining;
  logic [31:0]           w_expected;
  logic [31:0]           w_frag_next;
  logic                  w_at_len;
  logic                  w_close;
  logic                  w_is_end;

  assign w_trig_edge = trigger & ~r_trig_q;
  assign w_push      = s_axis_tvalid & s_axis_tready;
  assign w_pop       = m_axis_tvalid & m_axis_tready;
  assign w_remaining = r_size - r_frag_base;
  assign w_expected  = (r_mss < w_remaining) ? r_mss : w_remaining;
  assign w_frag_next = r_frag + 32'd1;
  assign w_at_len    = (w_frag_next == w_expected);
  assign w_close     = w_at_len | s_axis_tlast;
  assign w_is_end    = ((r_total + 32'd1) == r_size);

  assign m_axis_tvalid      = (r_cnt != 2'd0);
  assign m_axis_tdata       = m_axis_tvalid ? r_buf_data[r_rd_ptr] : '0;
  assign m_axis_tlast       = m_axis_tvalid & r_buf_last[r_rd_ptr];
  assign transfer_completed = r_done;
  assign fragment_count     = r_frag_cnt;
  assign err_short          = r_err_short;
  assign err_long           = r_err_long;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= WAIT_TRIGGER;
    else      r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next        = r_state;
    s_axis_tready = 1'b0;
    transfer_init = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      WAIT_TRIGGER: begin
        if (w_trig_edge) begin
          if (transfer_size == 32'd0) w_done_next = 1'b1;
          else                        w_next      = RECEIVE;
        end
      end
      RECEIVE: begin
        transfer_init = 1'b1;
        s_axis_tready = (r_cnt != 2'd2);
        if (w_push && w_is_end) w_next = DRAIN;
      end
      DRAIN: begin
        transfer_init = 1'b1;
        if (r_cnt == 2'd0) begin
          w_next      = WAIT_TRIGGER;
          w_done_next = 1'b1;
        end
      end
      default: w_next = WAIT_TRIGGER;
    endcase
  end

  // NOTE: the skid storage is reset too, so m_axis_tdata is a defined 0 straight out of reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      // Reset to 1 so a trigger already high at release is not taken as an edge.
      r_trig_q      <= 1'b1;
      r_done        <= 1'b0;
      r_mss         <= 32'd1;
      r_size        <= '0;
      r_total       <= '0;
      r_frag        <= '0;
      r_frag_base   <= '0;
      r_frag_cnt    <= '0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_trig_q <= trigger;
      r_done   <= w_done_next;
      if (r_state == WAIT_TRIGGER && w_trig_edge) begin
        r_mss       <= (mss == 32'd0) ? 32'd1 : mss;
        r_size      <= transfer_size;
        r_total     <= '0;
        r_frag      <= '0;
        r_frag_base <= '0;
        r_frag_cnt  <= '0;
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
      end else if (w_push) begin
        r_total <= r_total + 32'd1;
        if (w_close) begin
          r_frag      <= '0;
          r_frag_base <= r_total + 32'd1;
          if (r_frag_cnt != 16'hFFFF) r_frag_cnt <= r_frag_cnt + 16'd1;
        end else begin
          r_frag <= w_frag_next;
        end
        if (s_axis_tlast && !w_at_len) r_err_short <= 1'b1;
        if (w_at_len && !s_axis_tlast) r_err_long  <= 1'b1;
      end
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= s_axis_tdata;
        r_buf_last[r_wr_ptr] <= w_is_end;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_packet_reassembly.sv
// Scoreboard bench for packet_reassembly: input beats are queued at the handshake and
// compared in order against the m_axis stream, plus fragment/error/completion checks.
module tb_packet_reassembly;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          trigger = 1'b0;
  logic [31:0]   mss = '0;
  logic [31:0]   transfer_size = '0;
  logic          transfer_init;
  logic          transfer_completed;
  logic [15:0]   fragment_count;
  logic          err_short;
  logic          err_long;

  packet_reassembly #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .trigger(trigger), .mss(mss), .transfer_size(transfer_size),
    .transfer_init(transfer_init), .transfer_completed(transfer_completed),
    .fragment_count(fragment_count), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            mon_in_idx = 0;
  int            exp_size = 0;
  int            out_count = 0;
  int            done_count = 0;
  int            first_pop = 0;
  int            last_pop = 0;
  bit            hold_pending = 1'b0;
  logic [DW-1:0] held_data = '0;
  bit            rand_ready = 1'b0;
  bit            rand_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: pop/compare output first, then queue the beat the input accepts this cycle.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (arst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_data", m_axis_tdata, held_data);
        end
        hold_pending = 1'b0;
        if (m_axis_tvalid) begin
          if (m_axis_tready) begin
            if (sb.size() == 0) begin
              check("spurious_beat", 1, 0);
            end else begin
              b = sb.pop_front();
              check("out_data", m_axis_tdata, b.data);
              check("out_last", m_axis_tlast, b.last);
            end
            if (out_count == 0) first_pop = cyc;
            last_pop = cyc;
            out_count++;
          end else begin
            hold_pending = 1'b1;
            held_data    = m_axis_tdata;
          end
        end
        if (s_axis_tvalid && s_axis_tready) begin
          b.data = s_axis_tdata;
          b.last = (mon_in_idx == exp_size - 1);
          sb.push_back(b);
          mon_in_idx++;
        end
        if (transfer_completed) done_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_init", transfer_init, 0);
    check("rst_completed", transfer_completed, 0);
    check("rst_frag_count", fragment_count, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic start(input int mss_v, input int size_v);
    mss           = mss_v;
    transfer_size = size_v;
    mon_in_idx    = 0;
    exp_size      = size_v;
    out_count     = 0;
    pulse_trigger();
  endtask

  task automatic drive_beat(input logic [DW-1:0] data, input logic last);
    bit acc;
    int guard;
    while (rand_valid && $urandom_range(1, 0) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    guard = 0;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) check("accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] mask);
    logic [31:0] m;
    m = mask;
    for (int i = 0; i < n; i++) drive_beat({$urandom, $urandom}, m[i]);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && done_count == d0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", done_count - d0, 1);
    check("init_after_done", transfer_init, 0);
  endtask

  initial begin
    int  d0;
    bit  seen_ready;

    // Reset with trigger already high: no start at release.
    trigger = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_trigger_init", transfer_init, 0);
    check("held_trigger_ready", s_axis_tready, 0);
    trigger = 1'b0;
    @(posedge clk);
    #1;

    // Clean 4/4/2 transfer at full rate.
    d0 = done_count;
    start(4, 10);
    check("init_in_receive", transfer_init, 1);
    send(10, 32'h288);
    wait_done(d0);
    check("t1_frag_count", fragment_count, 3);
    check("t1_err_short", err_short, 0);
    check("t1_err_long", err_long, 0);
    check("t1_out_count", out_count, 10);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_throughput", last_pop - first_pop, 9);

    // Short first fragment (tlast on beat 2).
    d0 = done_count;
    start(4, 8);
    send(8, 32'hC4);
    wait_done(d0);
    check("t2_frag_count", fragment_count, 3);
    check("t2_err_short", err_short, 1);
    check("t2_err_long", err_long, 0);
    check("t2_out_count", out_count, 8);

    // Missing tlast on beat 3: boundary forced.
    d0 = done_count;
    start(4, 8);
    send(8, 32'h80);
    wait_done(d0);
    check("t3_frag_count", fragment_count, 2);
    check("t3_err_short", err_short, 0);
    check("t3_err_long", err_long, 1);
    check("t3_out_count", out_count, 8);

    // Random valid and backpressure.
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    d0 = done_count;
    start(3, 20);
    send(20, 32'hA4924);
    wait_done(d0);
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    check("t4_frag_count", fragment_count, 7);
    check("t4_err_short", err_short, 0);
    check("t4_err_long", err_long, 0);
    check("t4_out_count", out_count, 20);
    check("t4_sb_empty", sb.size(), 0);

    // Reset mid-transfer, then a fresh transfer.
    start(4, 10);
    send(5, 32'h8);
    #2;
    arst = 1'b1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    arst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    d0 = done_count;
    start(4, 10);
    send(10, 32'h288);
    wait_done(d0);
    check("t5_frag_count", fragment_count, 3);
    check("t5_err_short", err_short, 0);
    check("t5_out_count", out_count, 10);

    // Zero-length transfer: completion pulse, input never ready.
    d0 = done_count;
    seen_ready = 1'b0;
    start(4, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_axis_tready) seen_ready = 1'b1;
    end
    check("t6_no_ready", seen_ready, 0);
    wait_done(d0);

    // Second trigger edge during RECEIVE is ignored.
    d0 = done_count;
    start(4, 6);
    send(2, 32'h0);
    pulse_trigger();
    send(4, 32'hA);
    wait_done(d0);
    check("t7_frag_count", fragment_count, 2);
    check("t7_err_short", err_short, 0);
    check("t7_err_long", err_long, 0);
    check("t7_out_count", out_count, 6);

    // mss of 0 behaves as 1: every beat is its own fragment.
    d0 = done_count;
    start(0, 3);
    send(3, 32'h7);
    wait_done(d0);
    check("t8_frag_count", fragment_count, 3);
    check("t8_err_short", err_short, 0);
    check("t8_err_long", err_long, 0);
    check("t8_out_count", out_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_reassembly.md
PACKET_REASSEMBLY -- requirements
Module: packet_reassembly

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 64, the width of s_axis_tdata and m_axis_tdata in bits.
REQ-002 SHALL provide port clk, input, 1: single clock; all logic is on its rising edge.
REQ-003 SHALL provide port arst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL provide ports s_axis_tdata in DATA_WIDTH, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1: fragmented input stream, with tlast marking the end of each fragment.
REQ-005 SHALL provide ports m_axis_tdata out DATA_WIDTH, m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1: reassembled output stream, with tlast only on the final beat of a transfer.
REQ-006 SHALL provide inputs trigger 1, mss 32, transfer_size 32: start request, fragment length in beats, and total transfer length in beats.
REQ-007 SHALL provide outputs transfer_init 1, transfer_completed 1 (one-cycle pulse), fragment_count 16, err_short 1, err_long 1 (the error flags are sticky).

Function
REQ-008 SHALL implement the states WAIT_TRIGGER, RECEIVE and DRAIN.
REQ-009 SHALL detect a trigger rising edge from a registered copy of trigger; on that edge in WAIT_TRIGGER it SHALL capture mss and transfer_size, clear all counters and error flags, and enter RECEIVE on the next cycle.
REQ-010 SHALL ignore trigger edges while in RECEIVE or DRAIN.
REQ-011 SHALL treat a captured mss of 0 as 1.
REQ-012 SHALL, if the captured transfer_size is 0, go directly to WAIT_TRIGGER, pulse transfer_completed and accept no beats.
REQ-013 SHALL hold s_axis_tready at 0 outside RECEIVE.
REQ-014 SHALL, in RECEIVE, hold s_axis_tready at 1 whenever the internal 2-entry skid buffer has a free entry.
REQ-015 SHALL pass data through with 1-cycle latency: a beat accepted in cycle N appears on m_axis in cycle N+1 at the earliest.
REQ-016 SHALL sustain 1 beat/cycle at full throughput when m_axis_tready is held high.
REQ-017 SHALL keep m_axis_tvalid and m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0, and SHALL never drop or duplicate a beat.
REQ-018 SHALL count accepted beats in 32-bit counters: total_count, and frag_count, which restarts at each fragment boundary.
REQ-019 SHALL use expected fragment length = min(mss, transfer_size - beats accepted before the fragment started).
REQ-020 SHALL set err_short when an accepted beat carries tlast=1 with frag_count+1 < expected; that beat closes the fragment.
REQ-021 SHALL set err_long when an accepted beat with frag_count+1 == expected carries tlast=0; the fragment is still closed at that beat (the boundary is forced).
REQ-022 SHALL increment fragment_count at each fragment close, saturating at 16'hFFFF.
REQ-023 SHALL drive m_axis_tlast=1 only on the output beat that corresponds to accepted beat number transfer_size-1, independent of s_axis_tlast.
REQ-024 SHALL, on acceptance of beat transfer_size-1, drop s_axis_tready the next cycle and enter DRAIN.
REQ-025 SHALL, in DRAIN, enter WAIT_TRIGGER and pulse transfer_completed for 1 cycle once the skid buffer is empty and the tlast beat has been handshaken on m_axis.
REQ-026 SHALL drive transfer_init=1 in RECEIVE and DRAIN and 0 otherwise.
REQ-027 SHALL leave bits beyond a beat's own fragment unaffected: s_axis_tlast on a beat that is both a fragment close and the transfer end raises no error.

Reset
REQ-028 SHALL, on arst=1, immediately force WAIT_TRIGGER, empty the skid buffer and clear all counters, including mid-transfer.
REQ-029 SHALL drive the following values while in reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, transfer_init=0, transfer_completed=0, fragment_count=0, err_short=0, err_long=0.
REQ-030 SHALL not treat a trigger already high at reset release as an edge; it SHALL start only on a subsequent 0->1 transition.

Verification
REQ-031 SHALL cover: mss=4, transfer_size=10, three input fragments of 4/4/2 beats with correct tlast and m_axis_tready=1 -> 10 output beats in order at 1 beat/cycle, m_axis_tlast only on beat 9, fragment_count=3, no errors, one transfer_completed pulse.
REQ-032 SHALL cover: mss=4, transfer_size=8, first fragment with tlast on beat 2 -> err_short=1, fragment_count=3 at completion, and all 8 beats still delivered.
REQ-033 SHALL cover: mss=4, transfer_size=8, no tlast on beat 3 -> err_long=1, boundary forced at beat 3, and completion after 8 beats.
REQ-034 SHALL cover: random m_axis_tready (50%) and random s_axis_tvalid -> output sequence identical to input, with data stable whenever valid is held under backpressure.
REQ-035 SHALL cover: arst pulsed after 5 of 10 beats, then a retrigger -> all outputs at reset values, and the new transfer completes with fragment_count counted from 0.
REQ-036 SHALL cover: transfer_size=0 with a trigger edge -> transfer_completed pulse and no s_axis_tready; a second trigger edge during RECEIVE -> ignored.
